// File: rtl/dram_dma_master.sv
// dram_dma_master: single-channel word-burst DMA between a read/write stream pair and the DRAM port.
// Reads are credit-limited against a small FIFO so consumer backpressure never drops a word.
module dram_dma_master #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy,
    output logic                  done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q, cnt_q, pop_cnt_q;
    logic [1:0]            pipe_q;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;
    logic [CW:0]           occ;
    logic                  accept, rd_go, issue, push, pop, wr_hs, last_pop;

    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rd_valid  = count_q != '0;
    assign rd_data   = fifo_q[rptr_q];
    assign wr_ready  = state_q == WR && cnt_q != len_q;
    assign accept    = cmd_valid && cmd_ready;
    assign rd_go     = accept && !cmd_write && cmd_len != '0;
    // Words in flight already own a FIFO slot, so a stalled consumer can never overflow it.
    assign occ       = (CW+1)'(count_q) + (CW+1)'(pipe_q[0]) + (CW+1)'(pipe_q[1]);
    assign issue     = state_q == RD && cnt_q != len_q && occ < (CW+1)'(FIFO_DEPTH);
    assign push      = pipe_q[1];
    assign pop       = rd_valid && rd_ready;
    assign wr_hs     = wr_valid && wr_ready;
    assign last_pop  = pop && pop_cnt_q + LEN_WIDTH'(1) == len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            pop_cnt_q <= '0;
            pipe_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            done      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            pipe_q  <= {pipe_q[0], issue || rd_go};
            done    <= state_q == FIN;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (push) begin
                fifo_q[wptr_q] <= mem_dout;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            case (state_q)
                IDLE: if (accept) begin
                    len_q     <= cmd_len;
                    pop_cnt_q <= '0;
                    cnt_q     <= LEN_WIDTH'(rd_go);
                    addr_q    <= rd_go ? cmd_addr + ADDR_WIDTH'(4) : cmd_addr;
                    state_q   <= cmd_len == '0 ? FIN : (cmd_write ? WR : RD);
                    // The first read goes out on the accept edge itself.
                    if (rd_go) mem_addr <= cmd_addr;
                end
                RD: begin
                    if (issue) begin
                        mem_addr <= addr_q;
                        addr_q   <= addr_q + ADDR_WIDTH'(4);
                        cnt_q    <= cnt_q + LEN_WIDTH'(1);
                    end
                    if (pop) pop_cnt_q <= pop_cnt_q + LEN_WIDTH'(1);
                    if (last_pop) state_q <= FIN;
                end
                WR: begin
                    mem_we <= wr_hs;
                    if (wr_hs) begin
                        mem_addr <= addr_q;
                        mem_din  <= wr_data;
                        addr_q   <= addr_q + ADDR_WIDTH'(4);
                        cnt_q    <= cnt_q + LEN_WIDTH'(1);
                        if (cnt_q + LEN_WIDTH'(1) == len_q) state_q <= FIN;
                    end
                end
                FIN: begin
                    mem_we  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_dma_master.sv
// tb_dram_dma_master: scoreboard bench for dram_dma_master with a 1-cycle registered DRAM model.
// Expected read words and write beats are queued at stimulus time and retired by the monitor.
module tb_dram_dma_master;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [19:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        rd_valid, rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        busy, done;

    dram_dma_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int pop_n = 0, done_n = 0, done_c = 0, we_n = 0, last_pop = 0;
    int rise_q[$];
    logic [31:0] exp_rd[$], exp_wd[$];
    logic [19:0] exp_wa[$];
    logic        rv_prev = 1'b0;
    logic [31:0] dram [262144];
    bit          written [262144];

    function automatic logic [31:0] pattern(input logic [17:0] w);
        case (w)
            18'h40:  return 32'hA0A1A2A3;
            18'h41:  return 32'hB0B1B2B3;
            18'h42:  return 32'hC0C1C2C3;
            18'h43:  return 32'hD0D1D2D3;
            default: return 32'h5A00_0000 | 32'(w);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            dram[mem_addr[19:2]]    <= mem_din;
            written[mem_addr[19:2]] <= 1'b1;
        end
        mem_dout <= written[mem_addr[19:2]] ? dram[mem_addr[19:2]] : pattern(mem_addr[19:2]);
    end

    always @(negedge clk) begin
        if (rst) rv_prev = 1'b0;
        else begin
            if (rd_valid && !rv_prev) rise_q.push_back(cyc);
            rv_prev = rd_valid;
            if (rd_valid && rd_ready) begin
                pop_n++;
                last_pop = cyc;
                if (exp_rd.size() == 0) check("rd_unexpected", 32'(exp_rd.size()), 1);
                else check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (mem_we) begin
                we_n++;
                if (exp_wa.size() == 0) check("we_unexpected", 32'(exp_wa.size()), 1);
                else begin
                    check("we_addr", 32'(mem_addr), 32'(exp_wa.pop_front()));
                    check("we_data", mem_din, exp_wd.pop_front());
                end
            end
            if (done) begin
                done_n++;
                done_c = cyc;
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [19:0] a, input logic [15:0] l, output int acc);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic queue_reads(input logic [19:0] a, input int l);
        for (int i = 0; i < l; i++) begin
            logic [19:0] w = a + 20'(4 * i);
            exp_rd.push_back(pattern(w[19:2]));
        end
    endtask

    task automatic wait_done(input int n, input string tag);
        int t = 0;
        while (done_n < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(done_n >= n), 1);
        @(posedge clk); #1;
    endtask

    int acc, n0, nr, dn, wn, t, k, a5, a10, issued;
    logic hs;
    logic [19:0] ma;

    initial begin
        // Asynchronous reset, observed before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_din", mem_din, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Read burst of 4 with a free-running consumer.
        rd_ready = 1'b1;
        nr = rise_q.size(); n0 = pop_n; dn = done_n;
        queue_reads(20'h100, 4);
        send_cmd(1'b0, 20'h100, 16'd4, acc);
        check("rd_busy", busy, 1);
        wait_done(dn + 1, "rd_done_seen");
        repeat (3) @(posedge clk); #1;
        check("rd_first_lat", 32'(rise_q[nr] - acc), 2);
        check("rd_pops", 32'(pop_n - n0), 4);
        check("rd_streak", 32'(last_pop - rise_q[nr]), 3);
        check("rd_done_lat", 32'(done_c - last_pop), 2);
        check("rd_done_once", 32'(done_n - dn), 1);

        // Read of 16 with a 10-cycle consumer stall mid-burst.
        n0 = pop_n; dn = done_n;
        queue_reads(20'h100, 16);
        send_cmd(1'b0, 20'h100, 16'd16, acc);
        t = 0;
        while (pop_n < n0 + 4 && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1 rd_ready = 1'b0;
        repeat (5) @(posedge clk); #1 a5 = 32'(mem_addr);
        repeat (5) @(posedge clk); #1 a10 = 32'(mem_addr);
        check("bp_stall", 32'(a10), 32'(a5));
        issued = int'((mem_addr - 20'h100) >> 2) + 1;
        check("bp_fill", 32'(issued - (pop_n - n0)), 4);
        check("bp_valid", rd_valid, 1);
        rd_ready = 1'b1;
        wait_done(dn + 1, "bp_done_seen");
        repeat (3) @(posedge clk); #1;
        check("bp_pops", 32'(pop_n - n0), 16);
        check("bp_done_once", 32'(done_n - dn), 1);

        // Write of 3 words across the top of the address space.
        dn = done_n; wn = we_n;
        exp_wa.push_back(20'hFFFF8); exp_wd.push_back(32'd1);
        exp_wa.push_back(20'hFFFFC); exp_wd.push_back(32'd2);
        exp_wa.push_back(20'h00000); exp_wd.push_back(32'd3);
        send_cmd(1'b1, 20'hFFFF8, 16'd3, acc);
        k = 0; t = 0;
        while (k < 3 && t < 50) begin
            wr_valid = 1'b1; wr_data = 32'(k + 1);
            @(negedge clk);
            hs = wr_ready;
            @(posedge clk); #1;
            if (hs) k++;
            t++;
        end
        wr_valid = 1'b0;
        wait_done(dn + 1, "wr_done_seen");
        repeat (2) @(posedge clk); #1;
        check("wr_beats", 32'(we_n - wn), 3);
        check("wr_we_idle", mem_we, 0);

        // Read the written words back through the same wrap.
        dn = done_n;
        exp_rd.push_back(32'd1); exp_rd.push_back(32'd2); exp_rd.push_back(32'd3);
        send_cmd(1'b0, 20'hFFFF8, 16'd3, acc);
        wait_done(dn + 1, "rb_done_seen");

        // Zero-length read and write.
        ma = mem_addr; nr = rise_q.size(); dn = done_n;
        send_cmd(1'b0, 20'h200, 16'd0, acc);
        repeat (4) @(posedge clk); #1;
        check("z_rd_addr", 32'(mem_addr), 32'(ma));
        check("z_rd_valid", 32'(rise_q.size() - nr), 0);
        check("z_rd_done_n", 32'(done_n - dn), 1);
        check("z_rd_done_lat", 32'(done_c - acc), 1);
        wn = we_n; dn = done_n;
        send_cmd(1'b1, 20'h300, 16'd0, acc);
        repeat (4) @(posedge clk); #1;
        check("z_wr_we", 32'(we_n - wn), 0);
        check("z_wr_done_n", 32'(done_n - dn), 1);
        check("z_wr_done_lat", 32'(done_c - acc), 1);

        // Abort a read of 8 after two words have been consumed.
        rd_ready = 1'b0; n0 = pop_n; dn = done_n;
        queue_reads(20'h100, 8);
        send_cmd(1'b0, 20'h100, 16'd8, acc);
        repeat (6) @(posedge clk); #1 rd_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1 rd_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ab_pops", 32'(pop_n - n0), 2);
        check("ab_rd_valid", rd_valid, 0);
        check("ab_busy", busy, 0);
        check("ab_cmd_ready", cmd_ready, 1);
        check("ab_mem_we", mem_we, 0);
        exp_rd.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("ab_no_done", 32'(done_n - dn), 0);
        rd_ready = 1'b1; n0 = pop_n;
        queue_reads(20'h10C, 1);
        send_cmd(1'b0, 20'h10C, 16'd1, acc);
        wait_done(dn + 1, "ab_new_done");
        check("ab_new_pops", 32'(pop_n - n0), 1);

        check("rd_left", 32'(exp_rd.size()), 0);
        check("we_left", 32'(exp_wa.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
